// File: rtl/cx_multadd_pkg.sv
// Shared types and constants for the complex multiply-add datapath and its scheduler.
package cx_multadd_pkg;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned PHASE_WIDTH = 15;
    localparam int unsigned FRAC        = 14;
    localparam int unsigned MAC_WIDTH   = 24;
    localparam int unsigned CXMA_LAT    = 7;
    // Binary-point shift applied to C before it is added to A*B.
    localparam int unsigned ALIGN_BP    = FRAC;

    typedef logic signed [WIDTH-1:0]       sample_t;
    typedef logic signed [PHASE_WIDTH-1:0] phase_t;
    typedef logic signed [MAC_WIDTH-1:0]   mac_t;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, HELD} sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/cx_multadd_sched.sv
// Round-robin scheduler sharing one complex multiply-add pipe between NREQ requesters.
// Optional CXMA_SCHED_STATS_EN adds per-requester grant counters and a hold-cycle counter.
module cx_multadd_sched
    import cx_multadd_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = CXMA_LAT,
    parameter int unsigned AW   = WIDTH,
    parameter int unsigned BW   = PHASE_WIDTH,
    parameter int unsigned RW   = MAC_WIDTH,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*AW-1:0] req_a_re,
    input  logic [NREQ*AW-1:0] req_a_im,
    input  logic [NREQ*BW-1:0] req_b_re,
    input  logic [NREQ*BW-1:0] req_b_im,
    input  logic [NREQ*AW-1:0] req_c_re,
    input  logic [NREQ*AW-1:0] req_c_im,
    input  logic              hold,
    output logic              hold_ack,
    output logic              busy,
    output logic [AW-1:0]     op_a_re,
    output logic [AW-1:0]     op_a_im,
    output logic [BW-1:0]     op_b_re,
    output logic [BW-1:0]     op_b_im,
    output logic [AW-1:0]     op_c_re,
    output logic [AW-1:0]     op_c_im,
    input  logic [RW-1:0]     mac_re,
    input  logic [RW-1:0]     mac_im,
    output logic              res_valid,
    output logic [IW-1:0]     res_id,
    output logic [RW-1:0]     res_re,
    output logic [RW-1:0]     res_im
`ifdef CXMA_SCHED_STATS_EN
    ,
    output logic [NREQ*32-1:0] stat_grants,
    output logic [31:0]        stat_hold_cycles
`endif
);

    sched_state_t  state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] arb_idx;
    logic [NREQ-1:0] arb_grant;
    logic          grant_en;
    logic          xfer;
    logic [LAT:0]  tag_vld_q, tag_vld_d;
    logic [IW-1:0] tag_id_q [LAT+1];
    logic          busy_d;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign grant_en  = !rst && !hold && (state_q == IDLE || state_q == ACTIVE);
    assign req_ready = grant_en ? arb_grant : '0;
    assign xfer      = |req_ready;
    // Stage 0 is the issue register; stage LAT lines up with mac_* for that op.
    assign tag_vld_d = {tag_vld_q[LAT-1:0], xfer};
    assign busy_d    = |tag_vld_d;
    assign busy      = |tag_vld_q;

    // Transitions look at next-cycle occupancy so HELD coincides with busy falling.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hold) state_d = HELD;
                     else if (xfer) state_d = ACTIVE;
            ACTIVE:  if (hold) state_d = DRAIN;
                     else if (!busy_d) state_d = IDLE;
            DRAIN:   if (!hold) state_d = ACTIVE;
                     else if (!busy_d) state_d = HELD;
            HELD:    if (!hold) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_ack  <= 1'b0;
            ptr_q     <= IW'(NREQ - 1);
            tag_vld_q <= '0;
            for (int j = 0; j <= int'(LAT); j++) tag_id_q[j] <= '0;
            op_a_re   <= '0;
            op_a_im   <= '0;
            op_b_re   <= '0;
            op_b_im   <= '0;
            op_c_re   <= '0;
            op_c_im   <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_re    <= '0;
            res_im    <= '0;
        end else begin
            state_q   <= state_d;
            hold_ack  <= (state_d == HELD);
            if (xfer) ptr_q <= arb_idx;
            tag_vld_q   <= tag_vld_d;
            tag_id_q[0] <= xfer ? arb_idx : '0;
            for (int j = 1; j <= int'(LAT); j++) tag_id_q[j] <= tag_id_q[j-1];
            // Idle issue slots feed zeros so the shared pipe computes 0.
            op_a_re   <= xfer ? req_a_re[arb_idx*AW +: AW] : '0;
            op_a_im   <= xfer ? req_a_im[arb_idx*AW +: AW] : '0;
            op_b_re   <= xfer ? req_b_re[arb_idx*BW +: BW] : '0;
            op_b_im   <= xfer ? req_b_im[arb_idx*BW +: BW] : '0;
            op_c_re   <= xfer ? req_c_re[arb_idx*AW +: AW] : '0;
            op_c_im   <= xfer ? req_c_im[arb_idx*AW +: AW] : '0;
            res_valid <= tag_vld_q[LAT];
            res_id    <= tag_vld_q[LAT] ? tag_id_q[LAT] : '0;
            res_re    <= tag_vld_q[LAT] ? mac_re : '0;
            res_im    <= tag_vld_q[LAT] ? mac_im : '0;
        end
    end

`ifdef CXMA_SCHED_STATS_EN
    logic [31:0] grant_cnt_q [NREQ];
    logic [31:0] hold_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREQ); i++) grant_cnt_q[i] <= '0;
            hold_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_ready[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
            end
            if (state_q == DRAIN || state_q == HELD) hold_cnt_q <= hold_cnt_q + 32'd1;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < int'(NREQ); i++) stat_grants[i*32 +: 32] = grant_cnt_q[i];
    end

    assign stat_hold_cycles = hold_cnt_q;
`endif

endmodule
